tcam_rule_writer: RTL and testbench

- Update controller and front end for the 28-bit / 64-entry TCAM macro. The macro has four 7-bit slice blocks, each organised as 256 rows x 32 bits.
- Accepts high-level ternary rule commands: entry index, 28-bit value, 28-bit care mask.
- Keeps a shadow rule table and expands each rule into the per-slice one-hot row writes the macro needs.
- Forwards search keys to the macro while idle. Sits between the RoCC command decoder and the TCAM macro write/search port.

---
 rtl/tcam_rule_writer.sv | 221 ++++++++++++++++++++++
 tb/tb_tcam_rule_writer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_rule_writer.sv
// Rule-update front end for the 28-bit / 64-entry TCAM macro: keeps a shadow
// rule table, expands rules into per-slice one-hot row writes and forwards searches.
module tcam_rule_writer #(
  parameter int N_ENTRY = 64,
  parameter int N_BLK   = 4,
  parameter int SLICE_W = 7,
  parameter int KEY_W   = 28
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_idx,
  input  logic [KEY_W-1:0]   cmd_value,
  input  logic [KEY_W-1:0]   cmd_care,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic               busy,
  input  logic               srch_valid,
  output logic               srch_ready,
  input  logic [KEY_W-1:0]   srch_key,
  output logic               tcam_csb,
  output logic               tcam_web,
  output logic [N_BLK-1:0]   tcam_wmask,
  output logic [27:0]        tcam_addr,
  output logic [31:0]        tcam_wdata
);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_UPDATE, ST_RESP} state_t;

  state_t               state_q, state_d;
  logic [9:0]           cnt_q, cnt_d;
  logic                 clr_started_q, clr_started_d;
  logic                 clr_resp_q, clr_resp_d;
  logic [2:0]           grp_q, grp_d;
  logic [N_ENTRY-1:0]   valid_q, valid_d;
  logic [KEY_W-1:0]     value_mem [N_ENTRY];
  logic [KEY_W-1:0]     care_mem  [N_ENTRY];
  logic                 shadow_we;

  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;
  logic                 srch_ready_q, srch_ready_d;
  logic                 tcam_csb_q, tcam_csb_d;
  logic                 tcam_web_q, tcam_web_d;
  logic [N_BLK-1:0]     tcam_wmask_q, tcam_wmask_d;
  logic [27:0]          tcam_addr_q, tcam_addr_d;
  logic [31:0]          tcam_wdata_q, tcam_wdata_d;

  logic [7:0]           match_bits;
  logic [5:0]           mk;
  logic [KEY_W-1:0]     mval, mcare;
  logic [1:0]           sw_blk;
  logic [SLICE_W-1:0]   sw_v;

  function automatic logic [SLICE_W-1:0] slice_of(input logic [KEY_W-1:0] x,
                                                  input logic [1:0] blk);
    return x[SLICE_W*blk +: SLICE_W];
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clr_started_d = clr_started_q;
    clr_resp_d    = clr_resp_q;
    grp_d         = grp_q;
    valid_d       = valid_q;
    rsp_err_d     = 1'b0;
    shadow_we     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // Coming out of reset nothing has been written yet, so the first
        // cycle only launches address 0.
        if (!clr_started_q) begin
          clr_started_d = 1'b1;
          cnt_d         = '0;
        end else if (cnt_q == 10'd1023) begin
          clr_started_d = 1'b0;
          clr_resp_d    = 1'b0;
          state_d       = clr_resp_q ? ST_RESP : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'd0, 2'd1: begin
              valid_d[cmd_idx] = (cmd_op == 2'd0);
              shadow_we        = (cmd_op == 2'd0);
              grp_d            = cmd_idx[5:3];
              cnt_d            = '0;
              state_d          = ST_UPDATE;
            end
            2'd2: begin
              valid_d       = '0;
              cnt_d         = '0;
              clr_started_d = 1'b1;
              clr_resp_d    = 1'b1;
              state_d       = ST_CLEAR;
            end
            default: begin
              rsp_err_d = 1'b1;
              state_d   = ST_RESP;
            end
          endcase
        end
      end
      ST_UPDATE: begin
        if (cnt_q == 10'd511) state_d = ST_RESP;
        else                  cnt_d   = cnt_q + 10'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The write launched on accept must already see the new rule, so the
  // command data is forwarded over the not-yet-updated shadow entry.
  always_comb begin
    match_bits = '0;
    mk         = '0;
    mval       = '0;
    mcare      = '0;
    sw_blk     = cnt_d[8:7];
    sw_v       = cnt_d[6:0];
    for (int j = 0; j < 8; j++) begin
      mk    = {grp_d, 3'(j)};
      mval  = (shadow_we && mk == cmd_idx) ? cmd_value : value_mem[mk];
      mcare = (shadow_we && mk == cmd_idx) ? cmd_care  : care_mem[mk];
      match_bits[j] = valid_d[mk] &&
                      (((slice_of(mval, sw_blk) ^ sw_v) & slice_of(mcare, sw_blk)) == '0);
    end
  end

  always_comb begin
    cmd_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    srch_ready_d = (state_d == ST_IDLE);
    rsp_valid_d  = (state_d == ST_RESP);
    tcam_csb_d   = 1'b1;
    tcam_web_d   = 1'b1;
    tcam_wmask_d = '0;
    tcam_addr_d  = '0;
    tcam_wdata_d = '0;
    if (state_d == ST_CLEAR && clr_started_d) begin
      tcam_csb_d   = 1'b0;
      tcam_web_d   = 1'b0;
      tcam_wmask_d = '1;
      tcam_addr_d  = {18'b0, cnt_d};
    end else if (state_d == ST_UPDATE) begin
      tcam_csb_d   = 1'b0;
      tcam_web_d   = 1'b0;
      tcam_wmask_d = N_BLK'(1) << grp_d[1:0];
      tcam_addr_d  = {18'b0, cnt_d[8:7], grp_d[2], cnt_d[6:0]};
      tcam_wdata_d = {24'b0, match_bits} << {grp_d[1:0], 3'b000};
    end else if (state_q == ST_IDLE && !cmd_valid && srch_valid) begin
      tcam_csb_d  = 1'b0;
      tcam_addr_d = srch_key;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q       <= ST_CLEAR;
      cnt_q         <= '0;
      clr_started_q <= 1'b0;
      clr_resp_q    <= 1'b0;
      grp_q         <= '0;
      valid_q       <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b1;
      srch_ready_q  <= 1'b0;
      tcam_csb_q    <= 1'b1;
      tcam_web_q    <= 1'b1;
      tcam_wmask_q  <= '0;
      tcam_addr_q   <= '0;
      tcam_wdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clr_started_q <= clr_started_d;
      clr_resp_q    <= clr_resp_d;
      grp_q         <= grp_d;
      valid_q       <= valid_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      srch_ready_q  <= srch_ready_d;
      tcam_csb_q    <= tcam_csb_d;
      tcam_web_q    <= tcam_web_d;
      tcam_wmask_q  <= tcam_wmask_d;
      tcam_addr_q   <= tcam_addr_d;
      tcam_wdata_q  <= tcam_wdata_d;
    end
  end

  always_ff @(posedge in_clk) begin
    if (shadow_we && !in_rst) begin
      value_mem[cmd_idx] <= cmd_value;
      care_mem[cmd_idx]  <= cmd_care;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign srch_ready = srch_ready_q;
  assign tcam_csb   = tcam_csb_q;
  assign tcam_web   = tcam_web_q;
  assign tcam_wmask = tcam_wmask_q;
  assign tcam_addr  = tcam_addr_q;
  assign tcam_wdata = tcam_wdata_q;

endmodule

// File: tb/tb_tcam_rule_writer.sv
// Scoreboard bench for tcam_rule_writer: a shadow-table model queues every
// expected macro write, and each scenario task pops and compares them.
module tb_tcam_rule_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [5:0]  cmd_idx = '0;
  logic [27:0] cmd_value = '0;
  logic [27:0] cmd_care = '0;
  logic        rsp_valid, rsp_err, busy;
  logic        srch_valid = 1'b0;
  logic        srch_ready;
  logic [27:0] srch_key = '0;
  logic        tcam_csb, tcam_web;
  logic [3:0]  tcam_wmask;
  logic [27:0] tcam_addr;
  logic [31:0] tcam_wdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [27:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } wr_t;

  wr_t         exp_q[$];
  logic [63:0] m_valid = '0;
  logic [27:0] m_value [64];
  logic [27:0] m_care  [64];

  tcam_rule_writer dut (
    .in_clk(clk), .in_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_value(cmd_value), .cmd_care(cmd_care),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy),
    .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_key(srch_key),
    .tcam_csb(tcam_csb), .tcam_web(tcam_web), .tcam_wmask(tcam_wmask),
    .tcam_addr(tcam_addr), .tcam_wdata(tcam_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic push_clear();
    wr_t w;
    for (int i = 0; i < 1024; i++) begin
      w.addr = 28'(i); w.wmask = 4'hF; w.wdata = 32'h0;
      exp_q.push_back(w);
    end
  endtask

  task automatic push_update(input int e);
    wr_t w;
    logic [7:0] bits;
    logic [6:0] vs, cs, v;
    int blk, k;
    for (int c = 0; c < 512; c++) begin
      blk  = (c >> 7) & 3;
      v    = 7'(c & 127);
      bits = '0;
      for (int j = 0; j < 8; j++) begin
        k  = (e & 'h38) | j;
        vs = 7'((m_value[k] >> (7 * blk)) & 28'h7F);
        cs = 7'((m_care[k]  >> (7 * blk)) & 28'h7F);
        if (m_valid[k] && ((v ^ vs) & cs) == 7'h0) bits[j] = 1'b1;
      end
      w.addr  = 28'((blk << 8) | (((e >> 5) & 1) << 7) | (c & 127));
      w.wmask = 4'(1 << ((e >> 3) & 3));
      w.wdata = 32'(bits) << (8 * ((e >> 3) & 3));
      exp_q.push_back(w);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] idx,
                          input logic [27:0] val, input logic [27:0] care);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd_ready_wait: cmd_ready=%b after %0d cycles, need 1", cmd_ready, w);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_value = val; cmd_care = care;
    @(negedge clk);
    cmd_valid = 1'b0;
    case (op)
      2'd0: begin
        m_valid[idx] = 1'b1; m_value[idx] = val; m_care[idx] = care;
        push_update(int'(idx));
      end
      2'd1: begin
        m_valid[idx] = 1'b0;
        push_update(int'(idx));
      end
      2'd2: begin
        m_valid = '0;
        push_clear();
      end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    wr_t e;
    int n = 0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, busy, srch_ready} !== 5'b00010) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: rdy/rsp/err/busy/srdy=%b, need 00010",
               {cmd_ready, rsp_valid, rsp_err, busy, srch_ready});
    end
    checks++;
    if ({tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata} !== {2'b11, 4'h0, 28'h0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset_tcam: csb=%b web=%b mask=%h addr=%h data=%h, need 1 1 0 0 0",
               tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    push_clear();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({tcam_csb, tcam_web, rsp_valid, busy, tcam_addr, tcam_wmask, tcam_wdata} !==
          {4'b0001, e.addr, e.wmask, e.wdata}) begin
        errors++;
        $display("[TB] FAIL init_clear #%0d: csb=%b web=%b rsp=%b busy=%b addr=%h mask=%h data=%h, need addr=%h mask=%h data=%h busy=1",
                 n, tcam_csb, tcam_web, rsp_valid, busy, tcam_addr, tcam_wmask, tcam_wdata, e.addr, e.wmask, e.wdata);
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if ({cmd_ready, rsp_valid, busy, srch_ready, tcam_csb} !== 5'b10011) begin
      errors++;
      $display("[TB] FAIL init_idle: rdy/rsp/busy/srdy/csb=%b, need 10011",
               {cmd_ready, rsp_valid, busy, srch_ready, tcam_csb});
    end
  endtask

  // Shared by the write/invalidate scenarios; spot values are captured at
  // the sweep positions named by the caller and checked against constants.
  task automatic run_sweep(input string tag, input int pa, input int pb,
                           output logic [31:0] da, output logic [31:0] db);
    wr_t e;
    int n = 0;
    da = 'x; db = 'x;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({tcam_csb, tcam_web, rsp_valid, tcam_addr, tcam_wmask, tcam_wdata} !==
          {3'b000, e.addr, e.wmask, e.wdata}) begin
        errors++;
        $display("[TB] FAIL %s #%0d: csb=%b web=%b rsp=%b addr=%h mask=%h data=%h, need addr=%h mask=%h data=%h",
                 tag, n, tcam_csb, tcam_web, rsp_valid, tcam_addr, tcam_wmask, tcam_wdata, e.addr, e.wmask, e.wdata);
      end
      if (n == pa) da = tcam_wdata;
      if (n == pb) db = tcam_wdata;
      n++;
      @(negedge clk);
    end
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL %s_rsp: rsp_valid=%b rsp_err=%b, need 1 0", tag, rsp_valid, rsp_err);
    end
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL %s_idle: cmd_ready=%b rsp_valid=%b, need 1 0", tag, cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_write_single();
    logic [31:0] da, db;
    send_cmd(2'd0, 6'd5, 28'h0000012, 28'h000007F);
    run_sweep("write5", 'h12, 'h92, da, db);
    checks++;
    if (da !== 32'h20 || db !== 32'h20) begin
      errors++;
      $display("[TB] FAIL write5_spot: blk0 v12=%h blk1 v12=%h, need 20 20", da, db);
    end
  endtask

  task automatic test_write_neighbor();
    logic [31:0] da, db;
    send_cmd(2'd0, 6'd6, 28'h0000000, 28'h0000000);
    run_sweep("write6", 'h12, 'h11, da, db);
    checks++;
    if (da !== 32'h60 || db !== 32'h40) begin
      errors++;
      $display("[TB] FAIL write6_spot: blk0 v12=%h v11=%h, need 60 40", da, db);
    end
  endtask

  task automatic test_invalidate();
    logic [31:0] da, db;
    send_cmd(2'd1, 6'd5, 28'h0, 28'h0);
    run_sweep("inval5", 'h12, 'h1FF, da, db);
    checks++;
    if (da !== 32'h40 || db !== 32'h40) begin
      errors++;
      $display("[TB] FAIL inval5_spot: blk0 v12=%h blk3 v7f=%h, need 40 40", da, db);
    end
  endtask

  task automatic test_clear_all();
    wr_t e;
    int n = 0;
    send_cmd(2'd2, 6'd0, 28'h0, 28'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({tcam_csb, tcam_web, rsp_valid, tcam_addr, tcam_wmask, tcam_wdata} !==
          {3'b000, e.addr, e.wmask, e.wdata}) begin
        errors++;
        $display("[TB] FAIL clear_all #%0d: csb=%b web=%b rsp=%b addr=%h mask=%h data=%h, need addr=%h mask=%h data=%h",
                 n, tcam_csb, tcam_web, rsp_valid, tcam_addr, tcam_wmask, tcam_wdata, e.addr, e.wmask, e.wdata);
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL clear_all_rsp: rsp_valid=%b rsp_err=%b, need 1 0", rsp_valid, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reserved();
    send_cmd(2'd3, 6'd9, 28'h1234567, 28'hFFFFFFF);
    checks++;
    if ({rsp_valid, rsp_err, tcam_csb, tcam_web} !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL reserved_rsp: rsp=%b err=%b csb=%b web=%b, need 1 1 1 1",
               rsp_valid, rsp_err, tcam_csb, tcam_web);
    end
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, tcam_csb} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL reserved_idle: rdy=%b rsp=%b csb=%b, need 1 0 1", cmd_ready, rsp_valid, tcam_csb);
    end
  endtask

  task automatic test_search();
    checks++;
    if (srch_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL search_ready: srch_ready=%b, need 1", srch_ready);
    end
    srch_valid = 1'b1; srch_key = 28'h0ABCDEF;
    @(negedge clk);
    srch_valid = 1'b0;
    checks++;
    if ({tcam_csb, tcam_web, tcam_addr, tcam_wmask} !== {2'b01, 28'h0ABCDEF, 4'h0}) begin
      errors++;
      $display("[TB] FAIL search_issue: csb=%b web=%b addr=%h mask=%h, need 0 1 0abcdef 0",
               tcam_csb, tcam_web, tcam_addr, tcam_wmask);
    end
    @(negedge clk);
    checks++;
    if ({tcam_csb, tcam_web} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL search_idle: csb=%b web=%b, need 1 1", tcam_csb, tcam_web);
    end
  endtask

  task automatic test_cmd_wins();
    srch_valid = 1'b1; srch_key = 28'h5555555;
    send_cmd(2'd3, 6'd0, 28'h0, 28'h0);
    srch_valid = 1'b0;
    checks++;
    if ({tcam_csb, rsp_valid, rsp_err} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL cmd_wins: csb=%b rsp=%b err=%b addr=%h, need csb=1 rsp=1 err=1",
               tcam_csb, rsp_valid, rsp_err, tcam_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_search_busy();
    wr_t e;
    int n = 0;
    send_cmd(2'd0, 6'd42, 28'($urandom), 28'($urandom) & 28'h3F3F3F3);
    srch_valid = 1'b1; srch_key = 28'h0ABCDEF;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (n == 1) begin
        checks++;
        if ({srch_ready, busy} !== 2'b01) begin
          errors++;
          $display("[TB] FAIL busy_srdy: srch_ready=%b busy=%b, need 0 1", srch_ready, busy);
        end
      end
      checks++;
      if ({tcam_csb, tcam_web, rsp_valid, tcam_addr, tcam_wmask, tcam_wdata} !==
          {3'b000, e.addr, e.wmask, e.wdata}) begin
        errors++;
        $display("[TB] FAIL write42 #%0d: csb=%b web=%b rsp=%b addr=%h mask=%h data=%h, need addr=%h mask=%h data=%h",
                 n, tcam_csb, tcam_web, rsp_valid, tcam_addr, tcam_wmask, tcam_wdata, e.addr, e.wmask, e.wdata);
      end
      n++;
      @(negedge clk);
    end
    srch_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, tcam_csb} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL write42_rsp: rsp=%b err=%b csb=%b, need 1 0 1", rsp_valid, rsp_err, tcam_csb);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_update();
    wr_t e;
    int n = 0;
    send_cmd(2'd0, 6'd20, 28'($urandom), 28'($urandom));
    while (n < 200) begin
      e = exp_q.pop_front();
      checks++;
      if ({tcam_csb, tcam_web, rsp_valid, tcam_addr, tcam_wmask, tcam_wdata} !==
          {3'b000, e.addr, e.wmask, e.wdata}) begin
        errors++;
        $display("[TB] FAIL write20 #%0d: addr=%h mask=%h data=%h, need addr=%h mask=%h data=%h",
                 n, tcam_addr, tcam_wmask, tcam_wdata, e.addr, e.wmask, e.wdata);
      end
      n++;
      @(negedge clk);
    end
    rst = 1'b1;
    exp_q.delete();
    m_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({rsp_valid, busy, tcam_csb, tcam_addr} !== {3'b011, 28'h0}) begin
      errors++;
      $display("[TB] FAIL midrst_state: rsp=%b busy=%b csb=%b addr=%h, need 0 1 1 0",
               rsp_valid, busy, tcam_csb, tcam_addr);
    end
    @(negedge clk);
    push_clear();
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({tcam_csb, tcam_web, rsp_valid, tcam_addr, tcam_wmask, tcam_wdata} !==
          {3'b000, e.addr, e.wmask, e.wdata}) begin
        errors++;
        $display("[TB] FAIL midrst_clear #%0d: csb=%b web=%b rsp=%b addr=%h mask=%h data=%h, need addr=%h mask=%h data=%h",
                 n, tcam_csb, tcam_web, rsp_valid, tcam_addr, tcam_wmask, tcam_wdata, e.addr, e.wmask, e.wdata);
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL midrst_idle: rdy=%b rsp=%b busy=%b, need 1 0 0", cmd_ready, rsp_valid, busy);
    end
  endtask

  initial begin
    $display("[TB] starting tcam_rule_writer bench");
    test_reset();
    test_write_single();
    test_write_neighbor();
    test_invalidate();
    test_clear_all();
    test_reserved();
    test_search();
    test_cmd_wins();
    test_search_busy();
    test_reset_mid_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
